// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin arbitration.
// One operation is in flight at a time: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_reg, state_next;
  logic                prio_reg, prio_next;
  logic                grant_reg;
  logic [WIDTH-1:0]    a_reg, b_reg;
  logic [CTRL_W-1:0]   ctrl_reg;
  logic                sel;
  logic                accept;
  logic                resp_done;
  logic                ctrl_legal;

  // When both requesters are valid the priority bit decides; otherwise the lone valid one wins.
  assign sel = (req0_valid && req1_valid) ? prio_reg : req1_valid;

  assign ctrl_legal = (ctrl_reg == CTRL_W'(4'b0000)) || (ctrl_reg == CTRL_W'(4'b0001)) ||
                      (ctrl_reg == CTRL_W'(4'b0010)) || (ctrl_reg == CTRL_W'(4'b0110));

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_ctrl = ctrl_reg;

  always_comb begin
    state_next  = state_reg;
    prio_next   = prio_reg;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    accept      = 1'b0;
    resp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = req0_valid && !sel;
        req1_ready = req1_valid && sel;
        accept     = req0_valid || req1_valid;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp0_valid = !grant_reg;
        resp1_valid = grant_reg;
        resp_done   = grant_reg ? resp1_ready : resp0_ready;
        if (resp_done) begin
          prio_next  = ~grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      prio_reg    <= 1'b0;
      grant_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      ctrl_reg    <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      if (accept) begin
        grant_reg <= sel;
        a_reg     <= sel ? req1_a : req0_a;
        b_reg     <= sel ? req1_b : req0_b;
        ctrl_reg  <= sel ? req1_ctrl : req0_ctrl;
      end
      // Illegal codes never trust the ALU outputs.
      if (state_reg == EXEC) begin
        resp_result <= ctrl_legal ? alu_out : '0;
        resp_zero   <= ctrl_legal ? alu_zero : 1'b0;
        resp_err    <= !ctrl_legal;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the shared port.
module tb_alu_share_arbiter;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic        resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
  logic [31:0] resp_result, alu_a, alu_b, alu_out;
  logic        resp_zero, resp_err, alu_zero;
  logic [3:0]  alu_ctrl;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // External ALU; illegal codes produce junk that the arbiter must ignore.
  always_comb begin
    case (alu_ctrl)
      C_AND:   alu_out = alu_a & alu_b;
      C_OR:    alu_out = alu_a | alu_b;
      C_ADD:   alu_out = alu_a + alu_b;
      C_SUB:   alu_out = alu_a - alu_b;
      default: alu_out = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_ctrl inside {C_AND, C_OR, C_ADD, C_SUB}) ? (alu_out == 32'd0) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  // Single op from one requester with the response consumed immediately.
  task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [31:0] er, input logic ez, input logic ee);
    @(posedge clk); #1;
    drive(n, 1'b1, a, b, c);
    @(negedge clk);
    check($sformatf("op%0d_ready", n), {31'd0, (n == 0) ? req0_ready : req1_ready}, 32'd1);
    @(posedge clk); #1;
    drive(n, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    check($sformatf("op%0d_exec_noresp", n), {30'd0, resp1_valid, resp0_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("op%0d_resp_valid", n), {30'd0, resp1_valid, resp0_valid}, (n == 0) ? 32'd1 : 32'd2);
    check($sformatf("op%0d_result", n), resp_result, er);
    check($sformatf("op%0d_zero_err", n), {30'd0, resp_zero, resp_err}, {30'd0, ez, ee});
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_outputs", {27'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero | resp_err}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: ADD, latency T+2
    run_op(0, 32'd5, 32'd7, C_ADD, 32'd12, 1'b0, 1'b0);

    // 2: SUB equal and SUB wrapping
    run_op(1, 32'h1234, 32'h1234, C_SUB, 32'd0, 1'b1, 1'b0);
    run_op(1, 32'd3, 32'd5, C_SUB, 32'hFFFFFFFE, 1'b0, 1'b0);

    // 3: both valid after reset, round robin over three rounds
    pulse_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, 32'hF0, 32'h3C, C_AND);
    drive(1, 1'b1, 32'hF0, 32'h0C, C_OR);
    @(negedge clk);
    check("rr1_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr1_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    check("rr1_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    check("rr1_result", resp_result, 32'h30);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr2_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("rr2_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    check("rr2_result", resp_result, 32'hFC);
    @(posedge clk); #1;
    drive(1, 1'b1, 32'hF0, 32'h0C, C_OR);
    @(negedge clk);
    check("rr3_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("rr3_resp", {resp_result[29:0], resp1_valid, resp0_valid}, {30'h30, 2'b01});
    @(posedge clk); #1;

    // 4: stalled response; req1 waits, then gets served (prio now points at req1)
    resp0_ready = 1'b0;
    drive(0, 1'b1, 32'hFFFFFFFF, 32'd2, C_ADD);
    @(negedge clk);
    check("stall_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b1, 32'd10, 32'd4, C_SUB);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_hold", i), {resp_result[28:0], req1_ready, resp1_valid, resp0_valid},
            {29'd1, 3'b001});
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {31'd0, resp0_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_req1_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("stall_req1_resp", {resp_result[29:0], resp1_valid, resp0_valid}, {30'd6, 2'b10});
    @(posedge clk); #1;

    // 5: illegal control code, then a legal op from req0 (leaves prio=1)
    run_op(0, 32'd1, 32'd1, 4'b1111, 32'd0, 1'b0, 1'b1);
    run_op(1, 32'd2, 32'd3, C_ADD, 32'd5, 1'b0, 1'b0);
    run_op(0, 32'h100, 32'h0FF, C_OR, 32'h1FF, 1'b0, 1'b0);

    // 6a: reset while in EXEC
    drive(0, 1'b1, 32'hA5, 32'h5A, C_OR);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    #2 reset = 1'b1;
    #1;
    check("rst_exec_alu_a", alu_a, 32'd0);
    check("rst_exec_result", resp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_noresp", {30'd0, resp1_valid, resp0_valid}, 32'd0);

    // 6b: reset while in RESP
    @(posedge clk); #1;
    drive(1, 1'b1, 32'd40, 32'd2, C_ADD);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_resp", {resp_result[29:0], resp1_valid, resp0_valid}, {30'd42, 2'b10});
    #2 reset = 1'b1;
    #1;
    check("rst_resp_outputs", {resp_result[28:0], resp_err, resp1_valid, resp0_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b1, 32'd1, 32'd1, C_AND);
    drive(1, 1'b1, 32'd1, 32'd1, C_OR);
    @(negedge clk);
    check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
